// File: rtl/mod7_seq_checker.sv
// Sequence checker for a mod-7 up counter: locks on a sampled 0, then flags any
// deviation from 0,1,...,6,0 with an error pulse, sticky flag and counters.
module mod7_seq_checker (
  input  logic       clk,
  input  logic       set_n,
  input  logic       en,
  input  logic       q2,
  input  logic       q1,
  input  logic       q0,
  input  logic       clr_err,
  output logic       locked,
  output logic       err,
  output logic       err_sticky,
  output logic       exp2,
  output logic       exp1,
  output logic       exp0,
  output logic [7:0] wrap_cnt,
  output logic [7:0] err_cnt
);

  localparam logic [1:0] SYNC  = 2'd0;
  localparam logic [1:0] LOCK  = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  logic [1:0] state, state_nxt;
  logic [2:0] exp_q, exp_nxt;
  logic [2:0] q;
  logic       wrap, miss;

  assign q = {q2, q1, q0};
  assign {exp2, exp1, exp0} = exp_q;

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    exp_nxt   = exp_q;
    wrap      = 1'b0;
    miss      = 1'b0;
    if (en) begin
      case (state)
        SYNC, FAULT: begin
          if (q == 3'd0) begin
            state_nxt = LOCK;
            exp_nxt   = 3'd1;
          end
        end
        LOCK: begin
          if (q == exp_q) begin
            wrap    = (exp_q == 3'd6);
            exp_nxt = wrap ? 3'd0 : exp_q + 3'd1;
          end else begin
            // q=7 lands here too: it can never equal an expected value of 0..6.
            miss      = 1'b1;
            state_nxt = FAULT;
            exp_nxt   = 3'd0;
          end
        end
        default: begin
          state_nxt = SYNC;
          exp_nxt   = 3'd0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge set_n) begin
    if (!set_n) begin
      state      <= SYNC;
      exp_q      <= 3'd0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      wrap_cnt   <= 8'd0;
      err_cnt    <= 8'd0;
    end else begin
      state  <= state_nxt;
      exp_q  <= exp_nxt;
      locked <= (state_nxt == LOCK);
      err    <= miss;
      if (wrap && wrap_cnt != 8'hFF)
        wrap_cnt <= wrap_cnt + 8'd1;
      // A fresh error outranks a simultaneous clear: it becomes the first count.
      if (miss) begin
        err_sticky <= 1'b1;
        if (clr_err)
          err_cnt <= 8'd1;
        else if (err_cnt != 8'hFF)
          err_cnt <= err_cnt + 8'd1;
      end else if (clr_err) begin
        err_sticky <= 1'b0;
        err_cnt    <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_mod7_seq_checker.sv
// Self-checking bench for mod7_seq_checker: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the sequence rules.
module tb_mod7_seq_checker;

  logic       clk = 1'b0;
  logic       set_n, en, q2, q1, q0, clr_err;
  logic       locked, err, err_sticky, exp2, exp1, exp0;
  logic [7:0] wrap_cnt, err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: "searching" covers both SYNC and FAULT, which differ in name only.
  bit m_locked, m_err, m_sticky;
  int m_exp, m_wrap, m_errc;

  mod7_seq_checker dut (
    .clk(clk), .set_n(set_n), .en(en), .q2(q2), .q1(q1), .q0(q0),
    .clr_err(clr_err), .locked(locked), .err(err), .err_sticky(err_sticky),
    .exp2(exp2), .exp1(exp1), .exp0(exp0), .wrap_cnt(wrap_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] dut_vec();
    return {locked, err, err_sticky, exp2, exp1, exp0, wrap_cnt, err_cnt};
  endfunction

  function automatic logic [21:0] model_vec();
    logic [2:0] e;
    logic [7:0] w, c;
    e = m_locked ? 3'(m_exp) : 3'd0;
    w = 8'(m_wrap);
    c = 8'(m_errc);
    return {m_locked, m_err, m_sticky, e, w, c};
  endfunction

  task automatic model_reset();
    m_locked = 0; m_err = 0; m_sticky = 0;
    m_exp = 0; m_wrap = 0; m_errc = 0;
  endtask

  task automatic model_update(input bit e, input int qv, input bit c);
    bit miss = 0;
    if (e) begin
      if (!m_locked) begin
        if (qv == 0) begin m_locked = 1; m_exp = 1; end
      end else if (qv == m_exp) begin
        if (qv == 6 && m_wrap < 255) m_wrap++;
        m_exp = (m_exp + 1) % 7;
      end else begin
        miss = 1; m_locked = 0; m_exp = 0;
      end
    end
    m_err = miss;
    if (miss) begin
      m_sticky = 1;
      m_errc = c ? 1 : (m_errc < 255 ? m_errc + 1 : 255);
    end else if (c) begin
      m_sticky = 0; m_errc = 0;
    end
  endtask

  // Drive one sample, let the edge take it, then settle 1 time unit past the edge.
  task automatic step(input bit e, input int qv, input bit c);
    en = e; {q2, q1, q0} = 3'(qv); clr_err = c;
    @(posedge clk);
    model_update(e, qv, c);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    set_n = 1'b0; en = 0; {q2, q1, q0} = 3'd0; clr_err = 0;
    model_reset();
    #2;
    set_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [21:0] got;
    set_n = 1'b0; en = 0; {q2, q1, q0} = 3'd0; clr_err = 0;
    model_reset();
    #2;
    got = dut_vec();
    n_tests++;
    if (got !== 22'd0) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", got, 22'd0);
    end
    @(negedge clk); set_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_laps();
    logic [21:0] got, want;
    bit saw_err = 0;
    apply_reset();
    for (int i = 0; i < 22; i++) begin
      step(1, i % 7, 0);
      got = dut_vec(); want = model_vec();
      saw_err |= err;
      n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL laps[%0d]: got %h expected %h", i, got, want);
      end
      if (i == 0) begin
        n_tests++;
        if (locked !== 1'b1) begin
          n_fail++; $display("FAIL laps_lock_first: got %b expected 1", locked);
        end
      end
    end
    n_tests++;
    if (wrap_cnt !== 8'd3 || saw_err) begin
      n_fail++; $display("FAIL laps_wrap: got wrap %0d err_seen %0d expected 3 0", wrap_cnt, saw_err);
    end
  endtask

  task automatic test_mismatch();
    logic [21:0] got, want;
    apply_reset();
    for (int i = 0; i <= 3; i++) step(1, i, 0);
    n_tests++;
    if ({exp2, exp1, exp0} !== 3'd4) begin
      n_fail++; $display("FAIL mis_setup: got exp %0d expected 4", {exp2, exp1, exp0});
    end
    step(1, 5, 0);
    got = dut_vec(); want = {1'b0, 1'b1, 1'b1, 3'd0, 8'd0, 8'd1};
    n_tests++;
    if (got !== want) begin
      n_fail++; $display("FAIL mis_inject: got %h expected %h", got, want);
    end
    step(1, 3, 0);
    got = dut_vec(); want = {1'b0, 1'b0, 1'b1, 3'd0, 8'd0, 8'd1};
    n_tests++;
    if (got !== want) begin
      n_fail++; $display("FAIL mis_fault_hold: got %h expected %h", got, want);
    end
    step(1, 0, 0);
    got = dut_vec(); want = {1'b1, 1'b0, 1'b1, 3'd1, 8'd0, 8'd1};
    n_tests++;
    if (got !== want) begin
      n_fail++; $display("FAIL mis_relock: got %h expected %h", got, want);
    end
  endtask

  task automatic test_q7();
    logic [21:0] got, want;
    apply_reset();
    step(1, 7, 0);
    got = dut_vec();
    n_tests++;
    if (got !== 22'd0) begin
      n_fail++; $display("FAIL q7_sync: got %h expected %h", got, 22'd0);
    end
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 7, 0);
    got = dut_vec(); want = {1'b0, 1'b1, 1'b1, 3'd0, 8'd0, 8'd1};
    n_tests++;
    if (got !== want) begin
      n_fail++; $display("FAIL q7_lock: got %h expected %h", got, want);
    end
    step(1, 7, 0);
    got = dut_vec(); want = {1'b0, 1'b0, 1'b1, 3'd0, 8'd0, 8'd1};
    n_tests++;
    if (got !== want) begin
      n_fail++; $display("FAIL q7_fault: got %h expected %h", got, want);
    end
  endtask

  task automatic test_en_gap();
    logic [21:0] got, want;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      step(1, i % 7, 0);
      step(0, $urandom_range(0, 7), 0);
      got = dut_vec(); want = model_vec();
      n_tests++;
      if (got !== want || {exp2, exp1, exp0} !== 3'((i + 1) % 7)) begin
        n_fail++; $display("FAIL en_gap[%0d]: got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_clr_coincident();
    logic [21:0] got, want;
    apply_reset();
    step(1, 0, 0);
    step(1, 4, 0);
    step(1, 0, 0);
    step(1, 3, 1);
    got = dut_vec(); want = {1'b0, 1'b1, 1'b1, 3'd0, 8'd0, 8'd1};
    n_tests++;
    if (got !== want) begin
      n_fail++; $display("FAIL clr_with_err: got %h expected %h", got, want);
    end
    step(0, 0, 1);
    got = dut_vec(); want = 22'd0;
    n_tests++;
    if (got !== want) begin
      n_fail++; $display("FAIL clr_alone: got %h expected %h", got, want);
    end
  endtask

  task automatic test_async_reset();
    logic [21:0] got;
    apply_reset();
    for (int i = 0; i < 4; i++) step(1, i, 0);
    step(1, 4, 0);
    step(1, 0, 0);
    #2 set_n = 1'b0;
    model_reset();
    #1 got = dut_vec();
    n_tests++;
    if (got !== 22'd0) begin
      n_fail++; $display("FAIL async_reset: got %h expected %h", got, 22'd0);
    end
    #1 set_n = 1'b1;
    step(1, 3, 0);
    n_tests++;
    if (locked !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_q3: got locked %b err %b expected 0 0", locked, err);
    end
    step(1, 0, 0);
    n_tests++;
    if (locked !== 1'b1 || {exp2, exp1, exp0} !== 3'd1) begin
      n_fail++; $display("FAIL post_reset_q0: got locked %b exp %0d expected 1 1", locked, {exp2, exp1, exp0});
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 260 * 7; i++) step(1, i % 7, 0);
    n_tests++;
    if (wrap_cnt !== 8'd255 || model_vec() !== dut_vec()) begin
      n_fail++; $display("FAIL wrap_sat: got %0d expected 255", wrap_cnt);
    end
    for (int i = 0; i < 260; i++) begin
      step(1, 0, 0);
      step(1, 5, 0);
    end
    n_tests++;
    if (err_cnt !== 8'd255 || wrap_cnt !== 8'd255) begin
      n_fail++; $display("FAIL err_sat: got err_cnt %0d wrap %0d expected 255 255", err_cnt, wrap_cnt);
    end
  endtask

  task automatic test_random();
    logic [21:0] got, want;
    bit prev_err = 0;
    int qv;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 85) qv = m_locked ? m_exp : 0;
      else qv = $urandom_range(0, 7);
      step($urandom_range(0, 3) != 0, qv, $urandom_range(0, 19) == 0);
      got = dut_vec(); want = model_vec();
      n_tests++;
      if (got !== want || (prev_err && err)) begin
        n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, got, want);
      end
      prev_err = err;
    end
  endtask

  initial begin
    test_reset();
    test_laps();
    test_mismatch();
    test_q7();
    test_en_gap();
    test_clr_coincident();
    test_async_reset();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
